// File: rtl/ac_pkg.sv
// Shared Aho-Corasick table constants and builder FSM encoding.
package ac_pkg;

  localparam int unsigned ENTRIES = 32;
  localparam int unsigned STATE_W = 8;
  localparam int unsigned CHAR_W  = 4;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned CNT_W   = $clog2(ENTRIES + 1);

  localparam logic [STATE_W-1:0] ROOT = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSERT,
    S_BUILD_SCAN,
    S_BUILD_WALK,
    S_DONE
  } ac_state_t;

endpackage

// File: rtl/ac_goto_lookup.sv
// Parallel goto lookup: finds the trie entry leaving `state` on `chara`.
// Entry i always leads to state i+1, so the hit index is the next state.
module ac_goto_lookup
  import ac_pkg::*;
(
  input  logic [ENTRIES*STATE_W-1:0] cur_flat,
  input  logic [ENTRIES*CHAR_W-1:0]  chara_flat,
  input  logic [ENTRIES-1:0]         valid,
  input  logic [STATE_W-1:0]         state,
  input  logic [CHAR_W-1:0]          chara,
  output logic                       hit,
  output logic [STATE_W-1:0]         next
);

  // First valid entry matching (state, chara); the trie never holds duplicates.
  always_comb begin
    hit  = 1'b0;
    next = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!hit && valid[i] &&
          cur_flat[i*STATE_W +: STATE_W] == state &&
          chara_flat[i*CHAR_W +: CHAR_W] == chara) begin
        hit  = 1'b1;
        next = STATE_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/aho_table_writer.sv
// Runtime builder for the Aho-Corasick goto/terminal/failure tables.
// Inserts handshaked patterns into a trie mirror, then computes failure
// links breadth-first (by depth) when BUILD is pulsed.
module aho_table_writer
  import ac_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLEAR,
  input  logic               PAT_VALID,
  input  logic [CHAR_W-1:0]  PAT_CHAR,
  input  logic               PAT_LAST,
  output logic               PAT_READY,
  input  logic               BUILD,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR_FULL,
  output logic [CNT_W-1:0]   ENTRY_CNT,
  output logic               G_WR_EN,
  output logic [IDX_W-1:0]   G_WR_ADDR,
  output logic [STATE_W-1:0] G_WR_CUR,
  output logic [CHAR_W-1:0]  G_WR_CHARA,
  output logic [STATE_W-1:0] G_WR_NEXT,
  output logic               F_WR_EN,
  output logic [IDX_W-1:0]   F_WR_ADDR,
  output logic [STATE_W-1:0] F_WR_DATA,
  output logic               O_WR_EN,
  output logic [STATE_W-1:0] O_WR_STATE,
  output logic [ID_W-1:0]    O_WR_ID
);

  ac_state_t state_q, state_d;

  // Per-entry mirror; depth/fail are indexed by state-1 (entry e creates state e+1).
  logic [STATE_W-1:0] cur_tab   [ENTRIES];
  logic [CHAR_W-1:0]  chara_tab [ENTRIES];
  logic [STATE_W-1:0] depth_tab [ENTRIES];
  logic [STATE_W-1:0] fail_tab  [ENTRIES];

  logic [CNT_W-1:0]   cnt_q;
  logic [STATE_W-1:0] node_q, f_q, d_q, max_depth_q;
  logic [IDX_W-1:0]   e_q;
  logic [CHAR_W-1:0]  char_q;
  logic               last_q, skip_q, err_q;
  logic [ID_W-1:0]    id_q;

  logic [ENTRIES*STATE_W-1:0] cur_flat;
  logic [ENTRIES*CHAR_W-1:0]  chara_flat;
  logic [ENTRIES-1:0]         valid;
  logic [STATE_W-1:0]         lk_state, lk_next;
  logic [CHAR_W-1:0]          lk_char;
  logic                       lk_hit;

  logic [STATE_W-1:0] new_state, new_depth, ins_node, depth_node, fail_cur, fail_f, fail_val;
  logic tab_full, ins_alloc, ins_full, last_entry, last_depth, scan_hit;
  logic fail_wr, adv, f_load, f_step;

  // Present the mirror to the lookup as flat vectors with a valid mask.
  always_comb begin
    cur_flat   = '0;
    chara_flat = '0;
    valid      = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      cur_flat[i*STATE_W +: STATE_W] = cur_tab[i];
      chara_flat[i*CHAR_W +: CHAR_W] = chara_tab[i];
      valid[i]                       = CNT_W'(i) < cnt_q;
    end
  end

  // One lookup shared by insertion (node, char) and the failure walk (f, chara[e]).
  assign lk_state = (state_q == S_BUILD_WALK) ? f_q : node_q;
  assign lk_char  = (state_q == S_BUILD_WALK) ? chara_tab[e_q] : char_q;

  ac_goto_lookup u_lookup (
    .cur_flat   (cur_flat),
    .chara_flat (chara_flat),
    .valid      (valid),
    .state      (lk_state),
    .chara      (lk_char),
    .hit        (lk_hit),
    .next       (lk_next)
  );

  assign depth_node = (node_q == ROOT) ? '0 : depth_tab[IDX_W'(node_q - STATE_W'(1))];
  assign fail_cur   = (cur_tab[e_q] == ROOT) ? ROOT
                    : fail_tab[IDX_W'(cur_tab[e_q] - STATE_W'(1))];
  assign fail_f     = (f_q == ROOT) ? ROOT : fail_tab[IDX_W'(f_q - STATE_W'(1))];

  assign new_state  = STATE_W'(cnt_q) + STATE_W'(1);
  assign new_depth  = depth_node + STATE_W'(1);
  assign tab_full   = cnt_q == CNT_W'(ENTRIES);
  assign ins_alloc  = !skip_q && !lk_hit && !tab_full;
  assign ins_full   = !skip_q && !lk_hit && tab_full;
  assign ins_node   = (skip_q || ins_full) ? node_q : (lk_hit ? lk_next : new_state);
  assign last_entry = (CNT_W'(e_q) + CNT_W'(1)) == cnt_q;
  assign last_depth = d_q == max_depth_q;
  assign scan_hit   = depth_tab[e_q] == d_q;

  // Next-state and build-step decode.
  always_comb begin
    state_d  = state_q;
    fail_wr  = 1'b0;
    fail_val = ROOT;
    adv      = 1'b0;
    f_load   = 1'b0;
    f_step   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (PAT_VALID)  state_d = S_INSERT;
        else if (BUILD) state_d = (cnt_q == '0) ? S_DONE : S_BUILD_SCAN;
      end
      S_INSERT: state_d = S_IDLE;
      S_BUILD_SCAN: begin
        if (scan_hit && d_q != STATE_W'(1)) begin
          f_load  = 1'b1;
          state_d = S_BUILD_WALK;
        end else begin
          fail_wr = scan_hit;
          adv     = 1'b1;
        end
      end
      S_BUILD_WALK: begin
        if (lk_hit || f_q == ROOT) begin
          fail_wr  = 1'b1;
          fail_val = lk_hit ? lk_next : ROOT;
          adv      = 1'b1;
        end else begin
          f_step = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) state_d = (last_entry && last_depth) ? S_DONE : S_BUILD_SCAN;
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       state_q <= S_IDLE;
    else if (CLEAR) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Trie mirror storage; validity is governed solely by cnt_q, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (state_q == S_INSERT && ins_alloc) begin
      cur_tab[cnt_q[IDX_W-1:0]]   <= node_q;
      chara_tab[cnt_q[IDX_W-1:0]] <= char_q;
      depth_tab[cnt_q[IDX_W-1:0]] <= new_depth;
    end
    if (fail_wr) fail_tab[e_q] <= fail_val;
  end

  // Counters, insertion cursor, build cursor and registered write ports.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST || CLEAR) begin
      cnt_q <= '0; node_q <= '0; f_q <= '0; d_q <= '0; max_depth_q <= '0; e_q <= '0;
      char_q <= '0; last_q <= 1'b0; skip_q <= 1'b0; err_q <= 1'b0; id_q <= '0;
      G_WR_EN <= 1'b0; G_WR_ADDR <= '0; G_WR_CUR <= '0; G_WR_CHARA <= '0; G_WR_NEXT <= '0;
      F_WR_EN <= 1'b0; F_WR_ADDR <= '0; F_WR_DATA <= '0;
      O_WR_EN <= 1'b0; O_WR_STATE <= '0; O_WR_ID <= '0;
    end else begin
      G_WR_EN <= 1'b0;
      F_WR_EN <= 1'b0;
      O_WR_EN <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (PAT_VALID) begin
            char_q <= PAT_CHAR;
            last_q <= PAT_LAST;
          end else if (BUILD) begin
            d_q <= STATE_W'(1);
            e_q <= '0;
          end
        end
        S_INSERT: begin
          if (ins_alloc) begin
            G_WR_EN    <= 1'b1;
            G_WR_ADDR  <= cnt_q[IDX_W-1:0];
            G_WR_CUR   <= node_q;
            G_WR_CHARA <= char_q;
            G_WR_NEXT  <= new_state;
            cnt_q      <= cnt_q + CNT_W'(1);
            if (new_depth > max_depth_q) max_depth_q <= new_depth;
          end
          if (ins_full) err_q <= 1'b1;
          // Once a pattern overflows, its tail is consumed silently and it gets no terminal record.
          if (last_q) begin
            node_q <= ROOT;
            skip_q <= 1'b0;
            if (!(skip_q || ins_full)) begin
              O_WR_EN    <= 1'b1;
              O_WR_STATE <= ins_node;
              O_WR_ID    <= id_q;
              id_q       <= id_q + ID_W'(1);
            end
          end else begin
            node_q <= ins_node;
            skip_q <= skip_q | ins_full;
          end
        end
        default: ;
      endcase
      if (fail_wr) begin
        F_WR_EN   <= 1'b1;
        F_WR_ADDR <= e_q;
        F_WR_DATA <= fail_val;
      end
      if (f_load) f_q <= fail_cur;
      if (f_step) f_q <= fail_f;
      if (adv) begin
        if (last_entry) begin
          e_q <= '0;
          d_q <= d_q + STATE_W'(1);
        end else begin
          e_q <= e_q + IDX_W'(1);
        end
      end
    end
  end

  assign PAT_READY = (state_q == S_IDLE) || (state_q == S_DONE);
  assign BUSY      = (state_q == S_INSERT) || (state_q == S_BUILD_SCAN) || (state_q == S_BUILD_WALK);
  assign DONE      = state_q == S_DONE;
  assign ERR_FULL  = err_q;
  assign ENTRY_CNT = cnt_q;

endmodule
